// File: rtl/block_fifo.sv
// Block FIFO between the receive block assembler and the downstream consumer.
// First-word fall-through, sticky overflow flag and saturating drop counter.
module block_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    input  logic             clr_ovf,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_q, drop_d;

    logic is_full, is_empty, pop, accept, dropped;

    // Status comes from the registered count only, so outputs have no
    // combinational dependence on push or out_ready.
    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign pop      = !is_empty && out_ready;
    assign accept   = push && (!is_full || pop);
    assign dropped  = push && is_full && !pop;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        if (accept) wp_d = wp_q + AW'(1);
        if (pop)    rp_d = rp_q + AW'(1);

        if (accept && !pop)      count_d = count_q + CW'(1);
        else if (pop && !accept) count_d = count_q - CW'(1);

        // A clear in the same cycle as a drop wins.
        if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end else if (dropped) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Storage needs no reset; its contents are only observed behind out_valid.
    always_ff @(posedge clk) begin
        if (!rst && accept) mem_q[wp_q] <= push_data;
    end

    assign out_valid = !is_empty;
    assign out_data  = mem_q[rp_q];
    assign full      = is_full;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_block_fifo.sv
// Self-checking bench for block_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_block_fifo;
    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic [WIDTH-1:0] push_data = '0;
    logic             out_ready = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [7:0]       drop_cnt;

    block_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_data  (out_data),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf = 1'b0;
    int               m_drops = 0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit was_full, do_pop, do_acc, do_drop;
        if (rst) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
            return;
        end
        was_full = (m_q.size() == DEPTH);
        do_pop   = (m_q.size() > 0) && out_ready;
        do_acc   = push && (!was_full || do_pop);
        do_drop  = push && was_full && !do_pop;
        if (do_pop) void'(m_q.pop_front());
        if (do_acc) m_q.push_back(push_data);
        if (clr_ovf) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end else if (do_drop) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_q.size() != 0));
        chk({tag, ".count"},     64'(count),     64'(m_q.size()));
        chk({tag, ".full"},      64'(full),      64'(m_q.size() == DEPTH));
        chk({tag, ".overflow"},  64'(overflow),  64'(m_ovf));
        chk({tag, ".drop_cnt"},  64'(drop_cnt),  64'(m_drops));
        if (m_q.size() != 0) chk({tag, ".out_data"}, out_data, m_q[0]);
    endtask

    task automatic step(input string tag, input logic p, input logic [WIDTH-1:0] d,
                        input logic r, input logic c, input logic rs);
        @(negedge clk);
        push = p; push_data = d; out_ready = r; clr_ovf = c; rst = rs;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    logic [WIDTH-1:0] blk [6];

    initial begin
        blk[0] = 64'hA0A1A2A3A4A5A6A7;
        blk[1] = 64'hB0B1B2B3B4B5B6B7;
        blk[2] = 64'hC0C1C2C3C4C5C6C7;
        blk[3] = 64'hD0D1D2D3D4D5D6D7;
        blk[4] = 64'hE0E1E2E3E4E5E6E7;
        blk[5] = 64'hF0F1F2F3F4F5F6F7;

        // Reset, then single push with latency one; byte order preserved.
        step("rst0", 0, '0, 0, 0, 1);
        step("idle0", 0, '0, 1, 0, 0);
        step("push1", 1, 64'h0123456789ABCDEF, 0, 0, 0);
        chk("push1.byte0", 64'(out_data[7:0]), 64'hEF);

        // Fill, overflow by one, drain in order.
        step("rst1", 0, '0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("fill", 1, blk[i], 0, 0, 0);
        step("pushE", 1, blk[4], 0, 0, 0);
        chk("pushE.drop_cnt_abs", 64'(drop_cnt), 64'd1);
        for (int i = 0; i < 5; i++) step("drain", 0, '0, 1, 0, 0);

        // Push while full with simultaneous pop.
        step("rst2", 0, '0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("fill2", 1, blk[i], 0, 0, 0);
        step("pushF_pop", 1, blk[5], 1, 0, 0);
        for (int i = 0; i < 4; i++) step("drain2", 0, '0, 1, 0, 0);

        // Saturating drop counter, then clear.
        step("rst3", 0, '0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("fill3", 1, blk[i], 0, 0, 0);
        for (int i = 0; i < 300; i++) step("drop", 1, 64'($urandom), 0, 0, 0);
        chk("sat.drop_cnt_abs", 64'(drop_cnt), 64'd255);
        step("clr", 0, '0, 0, 1, 0);
        step("clr_drop", 1, '1, 0, 1, 0);
        chk("clr_drop.overflow_abs", 64'(overflow), 64'd0);

        // Streaming through with pointer wrap.
        step("rst4", 0, '0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step("stream", 1, {$urandom, $urandom}, 1, 0, 0);
        step("stream_end", 0, '0, 1, 0, 0);

        // Reset beats a coincident push.
        step("rst5", 0, '0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("fill5", 1, blk[i], 0, 0, 0);
        step("rst_push", 1, blk[3], 0, 0, 1);
        chk("rst_push.count_abs", 64'(count), 64'd0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step("rand",
                 ($urandom_range(99) < 60),
                 {$urandom, $urandom},
                 ($urandom_range(99) < 45),
                 ($urandom_range(99) < 3),
                 ($urandom_range(999) < 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
